// File: rtl/conv_arb.sv
// Round-robin arbiter that time-shares one combinational converter among four
// requesters. A granted code is registered onto conv_a, held for SETTLE cycles,
// then the converter result is captured and offered downstream until accepted.
// Optional feature macro: CONV_ARB_STATS_EN enables the txn_count statistic.
module conv_arb #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [3:0]  req_ready,
  output logic [3:0]  conv_a,
  input  logic [3:0]  conv_b,
  output logic        res_valid,
  output logic [3:0]  res_data,
  output logic [1:0]  res_id,
  input  logic        res_ready,
  output logic        busy,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  conv_a_q, conv_a_d;
  logic [3:0]  res_data_q, res_data_d;
  logic [1:0]  res_id_q, res_id_d;
  logic        res_valid_q, res_valid_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        found;
  logic [1:0]  win;
  logic [1:0]  cand;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant strobe only in IDLE; suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == StIdle) && found) begin
      req_ready[win] = 1'b1;
    end
  end

  // Next-state and datapath updates for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    conv_a_d    = conv_a_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          conv_a_d = req_data[{win, 2'b00} +: 4];
          res_id_d = win;
          cnt_d    = 4'(SETTLE - 1);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = conv_b;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = res_id_q + 2'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      conv_a_q    <= 4'd0;
      res_data_q  <= 4'd0;
      res_id_q    <= 2'd0;
      res_valid_q <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      conv_a_q    <= conv_a_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef CONV_ARB_STATS_EN
  logic [15:0] txn_q, txn_d;

  // Count result handshakes, saturating at all-ones.
  always_comb begin
    txn_d = txn_q;
    if ((state_q == StHold) && res_ready && (txn_q != 16'hFFFF)) begin
      txn_d = txn_q + 16'd1;
    end
  end

  // Statistic register.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_q <= 16'd0;
    end else begin
      txn_q <= txn_d;
    end
  end

  assign txn_count = txn_q;
`else
  assign txn_count = 16'd0;
`endif

  assign conv_a    = conv_a_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_arb.sv
// Directed bench for conv_arb: one instance at SETTLE=1, one at SETTLE=4.
// Converter model in the bench: conv_b = conv_a ^ (conv_a >> 1).
module tb_conv_arb;

`ifdef CONV_ARB_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic clk;
  int   checks;
  int   errors;

  // SETTLE = 1 instance
  logic        a_rst;
  logic [3:0]  a_req_valid;
  logic [15:0] a_req_data;
  logic [3:0]  a_req_ready;
  logic [3:0]  a_conv_a;
  logic [3:0]  a_conv_b;
  logic        a_res_valid;
  logic [3:0]  a_res_data;
  logic [1:0]  a_res_id;
  logic        a_res_ready;
  logic        a_busy;
  logic [15:0] a_txn_count;

  // SETTLE = 4 instance
  logic        b_rst;
  logic [3:0]  b_req_valid;
  logic [15:0] b_req_data;
  logic [3:0]  b_req_ready;
  logic [3:0]  b_conv_a;
  logic [3:0]  b_conv_b;
  logic        b_res_valid;
  logic [3:0]  b_res_data;
  logic [1:0]  b_res_id;
  logic        b_res_ready;
  logic        b_busy;
  logic [15:0] b_txn_count;

  assign a_conv_b = a_conv_a ^ (a_conv_a >> 1);
  assign b_conv_b = b_conv_a ^ (b_conv_a >> 1);

  conv_arb #(.SETTLE(1)) u_dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .req_valid (a_req_valid),
    .req_data  (a_req_data),
    .req_ready (a_req_ready),
    .conv_a    (a_conv_a),
    .conv_b    (a_conv_b),
    .res_valid (a_res_valid),
    .res_data  (a_res_data),
    .res_id    (a_res_id),
    .res_ready (a_res_ready),
    .busy      (a_busy),
    .txn_count (a_txn_count)
  );

  conv_arb #(.SETTLE(4)) u_dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .req_valid (b_req_valid),
    .req_data  (b_req_data),
    .req_ready (b_req_ready),
    .conv_a    (b_conv_a),
    .conv_b    (b_conv_b),
    .res_valid (b_res_valid),
    .res_data  (b_res_data),
    .res_id    (b_res_id),
    .res_ready (b_res_ready),
    .busy      (b_busy),
    .txn_count (b_txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          last_c;
    logic [1:0]  owner;
    logic [3:0]  s;
    logic [3:0]  exp_rr;

    checks = 0;
    errors = 0;
    a_rst = 1'b1; a_req_valid = 4'hF; a_req_data = 16'h0; a_res_ready = 1'b0;
    b_rst = 1'b1; b_req_valid = 4'hF; b_req_data = 16'h0; b_res_ready = 1'b0;

    // Reset with all requests asserted: no grant on either reset edge.
    cyc();
    check("rst_ready_e1", a_req_ready, 4'b0000);
    cyc();
    check("rst_ready_e2", a_req_ready, 4'b0000);
    a_rst = 1'b0; a_req_valid = 4'h0;
    b_rst = 1'b0; b_req_valid = 4'h0;
    #1;
    check("rst_res_valid", a_res_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_conv_a", a_conv_a, 4'd0);
    check("rst_txn", a_txn_count, 16'd0);

    // Single request from requester 2, code 0110 -> 0101.
    a_req_valid = 4'b0100; a_req_data = 16'h0600; a_res_ready = 1'b1;
    #1;
    check("single_ready_T", a_req_ready, 4'b0100);
    cyc();
    a_req_valid = 4'b0000;
    #1;
    check("single_busy_T1", a_busy, 1'b1);
    check("single_ready_T1", a_req_ready, 4'b0000);
    check("single_conv_a", a_conv_a, 4'b0110);
    check("single_valid_T1", a_res_valid, 1'b0);
    cyc();
    check("single_valid_T2", a_res_valid, 1'b1);
    check("single_data", a_res_data, 4'b0101);
    check("single_id", a_res_id, 2'd2);
    cyc();
    check("single_valid_T3", a_res_valid, 1'b0);
    check("single_busy_T3", a_busy, 1'b0);
    check("single_conv_a_kept", a_conv_a, 4'b0110);

    // Fairness from a fresh pointer: order 0,1,2,3,0 every 3 cycles.
    a_rst = 1'b1;
    cyc();
    a_rst = 1'b0;
    a_req_valid = 4'hF; a_req_data = 16'h4321; a_res_ready = 1'b1;
    #1;
    k = 0;
    last_c = 0;
    owner = 2'd0;
    for (int c = 0; c < 40; c++) begin
      if (a_res_valid) begin
        s = 4'(owner) + 4'd1;
        check("fair_res_id", a_res_id, owner);
        check("fair_res_data", a_res_data, s ^ (s >> 1));
      end
      if (a_req_ready != 4'b0000) begin
        exp_rr = 4'b0001 << (k % 4);
        check("fair_grant", a_req_ready, exp_rr);
        if (k > 0) check("fair_spacing", c - last_c, 3);
        if (k == 3) check("stats_txn3", a_txn_count, StatsOn ? 16'd3 : 16'd0);
        owner = 2'(k % 4);
        last_c = c;
        k++;
        if (k == 5) a_res_ready = 1'b0;
      end
      cyc();
      if (k == 5) break;
    end
    check("fair_grant_count", k, 5);

    // Back-pressure: result for requester 0 (code 1 -> 1) held for 10 cycles.
    cyc();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", a_res_valid, 1'b1);
      check("bp_data", a_res_data, 4'd1);
      check("bp_id", a_res_id, 2'd0);
      check("bp_ready", a_req_ready, 4'b0000);
      cyc();
    end
    a_res_ready = 1'b1;
    cyc();
    check("bp_idle_busy", a_busy, 1'b0);
    check("bp_idle_valid", a_res_valid, 1'b0);
    check("bp_next_grant", a_req_ready, 4'b0010);
    a_req_valid = 4'h0;
    #1;
    check("stats_txn5", a_txn_count, StatsOn ? 16'd5 : 16'd0);

    // SETTLE=4: full transaction from requester 1 (code 9 -> D), ptr ends at 2.
    b_req_valid = 4'b0010; b_req_data = 16'h0090; b_res_ready = 1'b1;
    #1;
    check("s4_grant1", b_req_ready, 4'b0010);
    cyc();
    b_req_valid = 4'b0000;
    cyc(); cyc(); cyc();
    check("s4_valid_T4", b_res_valid, 1'b0);
    cyc();
    check("s4_valid_T5", b_res_valid, 1'b1);
    check("s4_data", b_res_data, 4'hD);
    check("s4_id", b_res_id, 2'd1);
    cyc();
    check("s4_idle", b_busy, 1'b0);

    // Grant requester 3 from ptr 2, then reset in the second SETTLE cycle.
    b_req_valid = 4'b1010; b_req_data = 16'hA090;
    #1;
    check("s4_grant3", b_req_ready, 4'b1000);
    cyc();
    cyc();
    check("s4_mid_busy", b_busy, 1'b1);
    b_rst = 1'b1;
    cyc();
    b_rst = 1'b0;
    #1;
    check("s4_rst_busy", b_busy, 1'b0);
    check("s4_rst_valid", b_res_valid, 1'b0);
    check("s4_rst_conv_a", b_conv_a, 4'd0);
    check("s4_rst_grant", b_req_ready, 4'b0010);
    b_req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("s4_no_result", b_res_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
